pc_ras_unit: RTL

//  Parametrised program counter for the fetch stage, with a circular return-address stack (RAS).

---
 rtl/pc_ras_if.sv | 30 +++
 rtl/pc_ras_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/pc_ras_if.sv
// Fetch-stage PC bus: the control signals that steer the program counter,
// and the status/address signals that come back from it.
//   master : control side (drives halt, pc_wait, pc_src, load_imm, load_addr, jr_addr)
//   slave  : PC unit side (drives imemaddr, npc, halted, ras_empty, ras_full, ras_ovf)
interface pc_ras_if #(
    parameter int unsigned PC_W = 32
);
    logic            halt;
    logic            pc_wait;
    logic [2:0]      pc_src;
    logic [15:0]     load_imm;
    logic [25:0]     load_addr;
    logic [PC_W-1:0] jr_addr;
    logic [PC_W-1:0] imemaddr;
    logic [PC_W-1:0] npc;
    logic            halted;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_ovf;

    modport master (
        output halt, pc_wait, pc_src, load_imm, load_addr, jr_addr,
        input  imemaddr, npc, halted, ras_empty, ras_full, ras_ovf
    );

    modport slave (
        input  halt, pc_wait, pc_src, load_imm, load_addr, jr_addr,
        output imemaddr, npc, halted, ras_empty, ras_full, ras_ovf
    );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter for the fetch stage with a circular return-address stack.
// Next fetch address comes from NEXT/BRANCH/JUMP/JR/CALL/RET; CALL pushes the
// return address, RET pops it (falling back to the JR target when empty).
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : asynchronous reset, active-high
//   bus    : pc_ras_if.slave (control inputs, fetch address and status outputs)
module pc_ras_unit #(
    parameter int unsigned    PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pc_ras_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);
    // Upper PC bits kept by JUMP/CALL (everything above bit 27).
    localparam logic [PC_W-1:0] HiMask = ~PC_W'(32'h0FFF_FFFF);

    localparam logic [2:0] SrcNext   = 3'd0;
    localparam logic [2:0] SrcBranch = 3'd1;
    localparam logic [2:0] SrcJump   = 3'd2;
    localparam logic [2:0] SrcJr     = 3'd3;
    localparam logic [2:0] SrcCall   = 3'd4;
    localparam logic [2:0] SrcRet    = 3'd5;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            ovf_q, ovf_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic            push;

    logic [PC_W-1:0] npc;
    logic [PC_W-1:0] br_tgt, jmp_tgt, jr_tgt;

    assign npc     = pc_q + PC_W'(4);
    assign br_tgt  = npc + {{(PC_W-18){bus.load_imm[15]}}, bus.load_imm, 2'b00};
    assign jmp_tgt = (npc & HiMask) | PC_W'({bus.load_addr, 2'b00});
    assign jr_tgt  = {bus.jr_addr[PC_W-1:2], 2'b00};

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        ovf_d    = ovf_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        // Once halted nothing moves; halt wins over pc_wait on the same edge.
        if (!halted_q) begin
            if (bus.halt) begin
                halted_d = 1'b1;
            end else if (!bus.pc_wait) begin
                case (bus.pc_src)
                    SrcBranch: pc_d = br_tgt;
                    SrcJump:   pc_d = jmp_tgt;
                    SrcJr:     pc_d = jr_tgt;
                    SrcCall: begin
                        pc_d  = jmp_tgt;
                        push  = 1'b1;
                        ptr_d = ptr_q + PtrW'(1);
                        // Full push overwrites the oldest slot, which is exactly ptr+1.
                        if (cnt_q == CntFull) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + CntW'(1);
                    end
                    SrcRet: begin
                        if (cnt_q != '0) begin
                            pc_d  = ras_q[ptr_q];
                            ptr_d = ptr_q - PtrW'(1);
                            cnt_d = cnt_q - CntW'(1);
                        end else begin
                            pc_d = jr_tgt;
                        end
                    end
                    default:   pc_d = npc;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stack storage needs no reset: entries are only read when count > 0.
    always_ff @(posedge clk_i) begin
        if (push) ras_q[ptr_d] <= npc;
    end

    assign bus.imemaddr  = pc_q;
    assign bus.npc       = npc;
    assign bus.halted    = halted_q;
    assign bus.ras_empty = (cnt_q == '0);
    assign bus.ras_full  = (cnt_q == CntFull);
    assign bus.ras_ovf   = ovf_q;
endmodule
